// File: rtl/uart_break_reset_req_if.sv
// UART break reset request bus: raw RX line and enable in, request pulse,
// timing flag and saturating request count out.
// Ports: rx_in, enable (to design); reset_req, break_active, req_count (from design).
interface uart_break_reset_req_if;
    logic       rx_in;
    logic       enable;
    logic       reset_req;
    logic       break_active;
    logic [3:0] req_count;

    modport master (
        output rx_in,
        output enable,
        input  reset_req,
        input  break_active,
        input  req_count
    );

    modport slave (
        input  rx_in,
        input  enable,
        output reset_req,
        output break_active,
        output req_count
    );
endinterface

// File: rtl/uart_break_reset_req.sv
// UART break detector: a low RX line held for BREAK_BITS bit times issues a
// fixed-width reset request pulse; re-arms only after the line idles high.
// Ports: clk, rst_n (sync, active-low), bus (slave): rx_in, enable,
//        reset_req, break_active, req_count.
// Option: define UART_BREAK_GLITCH_FILTER_EN to ignore single-cycle highs
//         while timing a break.
module uart_break_reset_req #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned BREAK_BITS   = 20,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_break_reset_req_if.slave bus
);

    localparam int unsigned T  = BREAK_BITS * CLKS_PER_BIT;
    localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    generate
        if (64'(T) >= (64'd1 << CNT_W)) begin : g_cnt_too_small
            $error("CNT_W too narrow for BREAK_BITS*CLKS_PER_BIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_ASSERT,
        S_WAIT
    } state_t;

    logic             r_sync1;
    logic             r_rx_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_pcnt;
    logic             r_reset_req;
    logic             r_break_active;
    logic [3:0]       r_req_count;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PW-1:0]    w_pcnt_nxt;
    logic             w_req_inc;
    logic             w_reset_req_nxt;
    logic             w_break_active_nxt;
    logic [3:0]       w_req_count_nxt;

`ifdef UART_BREAK_GLITCH_FILTER_EN
    // Set after one high sample in COUNT; a second consecutive high aborts.
    logic r_hi;
    logic w_hi_nxt;
`endif

    // State register, synchronizer and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1        <= 1'b1;
            r_rx_s         <= 1'b1;
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_pcnt         <= '0;
            r_reset_req    <= 1'b0;
            r_break_active <= 1'b0;
            r_req_count    <= 4'd0;
`ifdef UART_BREAK_GLITCH_FILTER_EN
            r_hi           <= 1'b0;
`endif
        end else begin
            r_sync1        <= bus.rx_in;
            r_rx_s         <= r_sync1;
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_pcnt         <= w_pcnt_nxt;
            r_reset_req    <= w_reset_req_nxt;
            r_break_active <= w_break_active_nxt;
            r_req_count    <= w_req_count_nxt;
`ifdef UART_BREAK_GLITCH_FILTER_EN
            r_hi           <= w_hi_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pcnt_nxt  = r_pcnt;
        w_req_inc   = 1'b0;
`ifdef UART_BREAK_GLITCH_FILTER_EN
        w_hi_nxt    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.enable && !r_rx_s) begin
                    w_state_nxt = S_COUNT;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            S_COUNT: begin
                // Losing enable wins over reaching the threshold.
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (!r_rx_s) begin
                    if (r_cnt == CNT_W'(T - 1)) begin
                        w_state_nxt = S_ASSERT;
                        w_cnt_nxt   = '0;
                        w_pcnt_nxt  = '0;
                        w_req_inc   = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end else begin
`ifdef UART_BREAK_GLITCH_FILTER_EN
                    if (r_hi) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_hi_nxt    = 1'b1;
                    end
`else
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
`endif
                end
            end
            S_ASSERT: begin
                if (r_pcnt == PW'(PULSE_CYCLES - 1)) begin
                    w_state_nxt = S_WAIT;
                    w_pcnt_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_pcnt_nxt  = r_pcnt + PW'(1);
                end
            end
            S_WAIT: begin
                // Need a full bit time of idle line before re-arming.
                if (r_rx_s) begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_pcnt_nxt  = '0;
            end
        endcase
    end

    // Output logic, registered from the next state so outputs are glitch-free
    always_comb begin
        w_reset_req_nxt    = (w_state_nxt == S_ASSERT);
        w_break_active_nxt = (w_state_nxt == S_COUNT);
        w_req_count_nxt    = r_req_count;
        if (w_req_inc && (r_req_count != 4'hF)) begin
            w_req_count_nxt = r_req_count + 4'd1;
        end
    end

    assign bus.reset_req    = r_reset_req;
    assign bus.break_active = r_break_active;
    assign bus.req_count    = r_req_count;

endmodule

// File: tb/tb_uart_break_reset_req.sv
// Testbench for uart_break_reset_req: cycle model of the break rules plus
// directed scenarios with literal expectations.
module tb_uart_break_reset_req;

    localparam int CPB   = 4;
    localparam int BB    = 5;
    localparam int PULSE = 3;
    localparam int T     = CPB * BB;
`ifdef UART_BREAK_GLITCH_FILTER_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    uart_break_reset_req_if bus ();

    uart_break_reset_req #(
        .CLKS_PER_BIT (CPB),
        .BREAK_BITS   (BB),
        .PULSE_CYCLES (PULSE),
        .CNT_W        (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: low-run length, pulse cycles left, idle-run while re-arming.
    bit m_started;
    bit m_s1, m_s2;
    int m_run, m_pulse, m_hrun, m_cnt;
    bit m_wait, m_prevhi;

    always @(posedge clk) begin
        bit rs;
        m_started = 1'b1;
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_run = 0; m_pulse = 0; m_hrun = 0; m_cnt = 0;
            m_wait = 1'b0; m_prevhi = 1'b0;
        end else begin
            rs   = m_s2;
            m_s2 = m_s1;
            m_s1 = bus.rx_in;
            if (m_pulse > 0) begin
                m_pulse--;
                if (m_pulse == 0) begin
                    m_wait = 1'b1;
                    m_hrun = 0;
                end
            end else if (m_wait) begin
                m_hrun = rs ? m_hrun + 1 : 0;
                if (m_hrun == CPB) m_wait = 1'b0;
            end else if (!bus.enable) begin
                m_run = 0; m_prevhi = 1'b0;
            end else if (!rs) begin
                m_run++;
                m_prevhi = 1'b0;
                if (m_run == T) begin
                    m_run = 0;
                    m_pulse = PULSE;
                    if (m_cnt < 15) m_cnt++;
                end
            end else if (GLITCH && m_run > 0 && !m_prevhi) begin
                m_prevhi = 1'b1;
            end else begin
                m_run = 0; m_prevhi = 1'b0;
            end
        end
    end

    // Compare process plus pulse-width monitor
    int pulses, cur_w, last_w;
    initial begin pulses = 0; cur_w = 0; last_w = 0; end

    always @(negedge clk) begin
        if (m_started) begin
            checks++;
            if (bus.reset_req !== (m_pulse > 0) ||
                bus.break_active !== (m_run > 0) ||
                bus.req_count !== 4'(m_cnt)) begin
                errors++;
                $display("FAIL cycle_model t=%0t got req=%b act=%b cnt=%0d expected req=%b act=%b cnt=%0d",
                         $time, bus.reset_req, bus.break_active, bus.req_count,
                         (m_pulse > 0), (m_run > 0), m_cnt);
            end
            if (bus.reset_req === 1'b1) begin
                cur_w++;
            end else if (cur_w > 0) begin
                last_w = cur_w;
                pulses++;
                cur_w = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.rx_in = 1'b1;
        bus.enable = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    // Low for nlow cycles then high for nhigh; rise = cycles from fall to reset_req.
    task automatic run(input int nlow, input int nhigh, output int rise);
        rise = -1;
        bus.rx_in = 1'b0;
        for (int i = 1; i <= nlow + nhigh; i++) begin
            tick();
            if (i == nlow) bus.rx_in = 1'b1;
            if (bus.reset_req === 1'b1 && rise < 0) rise = i;
        end
    endtask

    int rise;
    int p0;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.rx_in = 1'b0;
        bus.enable = 1'b1;

        repeat (3) begin
            tick();
            chk("rst_req", int'(bus.reset_req), 0);
            chk("rst_active", int'(bus.break_active), 0);
            chk("rst_count", int'(bus.req_count), 0);
        end
        rst_n = 1'b1;
        tick(); chk("rel_active1", int'(bus.break_active), 0);
        tick(); chk("rel_active2", int'(bus.break_active), 0);
        tick(); chk("rel_active3", int'(bus.break_active), 1);
        bus.rx_in = 1'b1;
        repeat (12) tick();
        chk("abort_count", int'(bus.req_count), 0);

        p0 = pulses;
        run(40, 15, rise);
        chk("clean_rise", rise, 22);
        chk("clean_pulses", pulses - p0, 1);
        chk("clean_width", last_w, 3);
        chk("clean_count", int'(bus.req_count), 1);

        do_reset();
        p0 = pulses;
        run(19, 15, rise);
        chk("short19_rise", rise, -1);
        chk("short19_pulses", pulses - p0, 0);
        chk("short19_count", int'(bus.req_count), 0);
        run(20, 15, rise);
        chk("exact20_rise", rise, 22);
        chk("exact20_pulses", pulses - p0, 1);
        chk("exact20_count", int'(bus.req_count), 1);

        do_reset();
        p0 = pulses;
        run(40, 3, rise);
        chk("rearm_first", rise, 22);
        run(30, 6, rise);
        chk("rearm_blocked", rise, -1);
        run(30, 12, rise);
        chk("rearm_second", rise, 22);
        chk("rearm_pulses", pulses - p0, 2);
        chk("rearm_count", int'(bus.req_count), 2);

        do_reset();
        p0 = pulses;
        rise = -1;
        bus.rx_in = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 9) chk("en_active_before", int'(bus.break_active), 1);
            if (i == 10) bus.enable = 1'b0;
            if (i == 12) chk("en_active_after", int'(bus.break_active), 0);
            if (bus.reset_req === 1'b1 && rise < 0) rise = i;
        end
        bus.rx_in = 1'b1;
        repeat (12) tick();
        bus.enable = 1'b1;
        chk("en_drop_rise", rise, -1);

        rise = -1;
        bus.rx_in = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 21) bus.enable = 1'b0;
            if (bus.reset_req === 1'b1 && rise < 0) rise = i;
        end
        bus.rx_in = 1'b1;
        repeat (12) tick();
        bus.enable = 1'b1;
        chk("en_thresh_rise", rise, -1);
        chk("en_pulses", pulses - p0, 0);
        chk("en_count", int'(bus.req_count), 0);

        do_reset();
        p0 = pulses;
        repeat (16) run(25, 12, rise);
        chk("sat_pulses", pulses - p0, 16);
        chk("sat_count", int'(bus.req_count), 15);

        do_reset();
        p0 = pulses;
        bus.rx_in = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (i == 10) bus.rx_in = 1'b1;
            if (i == 11) bus.rx_in = 1'b0;
            if (i == 30) bus.rx_in = 1'b1;
        end
        chk("glitch_pulses", pulses - p0, GLITCH ? 1 : 0);
        chk("glitch_count", int'(bus.req_count), GLITCH ? 1 : 0);

        do_reset();
        bus.rx_in = 1'b0;
        for (int i = 1; i <= 23; i++) tick();
        chk("midpulse_high", int'(bus.reset_req), 1);
        rst_n = 1'b0;
        tick();
        chk("midpulse_cut", int'(bus.reset_req), 0);
        chk("midpulse_count", int'(bus.req_count), 0);
        rst_n = 1'b1;
        bus.rx_in = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
